// File: rtl/calc_sequencer.sv
// Sequences one calculator op through the one-hot result mux.
// Multi-cycle units get a start pulse and a bounded completion wait.
module calc_sequencer #(
  parameter int          WIDTH   = 32,
  parameter logic [15:0] MC_MASK = 16'h0C00,
  parameter int          TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic             clear,
  input  logic [WIDTH-1:0] muxout,
  input  logic             unit_done,
  output logic [15:0]      hotselect,
  output logic             unit_start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       last_op,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SELECT,
    S_WAIT
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [15:0]      hot_q, hot_d;
  logic             ustart_q, ustart_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       last_q, last_d;
  logic             err_q, err_d;
  logic             multi;
  logic             expired;

  assign multi   = MC_MASK[op_q];
  assign expired = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      hot_q    <= '0;
      ustart_q <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      last_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      hot_q    <= hot_d;
      ustart_q <= ustart_d;
      done_q   <= done_d;
      result_q <= result_d;
      last_q   <= last_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (!clear && start) state_d = S_SELECT;
      S_SELECT:
        state_d = multi ? S_WAIT : S_IDLE;
      S_WAIT:
        if (unit_done || expired) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // unit_done is checked before the timeout so a last-cycle completion is not an error
  always_comb begin
    op_d     = op_q;
    cnt_d    = cnt_q;
    hot_d    = hot_q;
    ustart_d = 1'b0;
    done_d   = 1'b0;
    result_d = result_q;
    last_d   = last_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (clear) begin
          result_d = '0;
          last_d   = '0;
          err_d    = 1'b0;
        end else if (start) begin
          op_d   = opcode;
          last_d = opcode;
          err_d  = 1'b0;
          hot_d  = 16'h0001 << opcode;
        end
      end
      S_SELECT: begin
        if (!multi) begin
          result_d = muxout;
          done_d   = 1'b1;
          hot_d    = '0;
        end else begin
          ustart_d = 1'b1;
          cnt_d    = '0;
        end
      end
      S_WAIT: begin
        if (unit_done) begin
          result_d = muxout;
          done_d   = 1'b1;
          hot_d    = '0;
        end else if (expired) begin
          err_d  = 1'b1;
          done_d = 1'b1;
          hot_d  = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        hot_d = '0;
      end
    endcase
  end

  assign hotselect  = hot_q;
  assign unit_start = ustart_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign result     = result_q;
  assign last_op    = last_q;
  assign err        = err_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: per-op age model checked every cycle,
// plus directed literal checks.
module tb_calc_sequencer;

  localparam int          W  = 32;
  localparam int          TO = 8;
  localparam logic [15:0] MC = 16'h0C00;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   opcode = '0;
  logic         clear = 1'b0;
  logic [W-1:0] muxout = '0;
  logic         unit_done = 1'b0;
  logic [15:0]  hotselect;
  logic         unit_start;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [3:0]   last_op;
  logic         err;

  calc_sequencer #(.WIDTH(W), .MC_MASK(MC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .clear(clear), .muxout(muxout), .unit_done(unit_done),
    .hotselect(hotselect), .unit_start(unit_start), .busy(busy),
    .done(done), .result(result), .last_op(last_op), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  // Model: an accepted op is tracked by edges elapsed since acceptance
  bit           m_busy;
  int           m_age;
  logic [3:0]   m_op;
  logic         m_done, m_us, m_err;
  logic [W-1:0] m_res;
  logic [3:0]   m_last;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_age = 0; m_op = '0; m_done = 0; m_us = 0;
      m_err = 0; m_res = '0; m_last = '0;
    end else begin
      m_done = 0;
      m_us   = 0;
      if (!m_busy) begin
        if (clear) begin
          m_res = '0; m_last = '0; m_err = 0;
        end else if (start) begin
          m_busy = 1; m_age = 0; m_op = opcode;
          m_last = opcode; m_err = 0;
        end
      end else begin
        m_age++;
        if (!MC[m_op]) begin
          m_res = muxout; m_done = 1; m_busy = 0;
        end else if (m_age == 1) begin
          m_us = 1;
        end else if (unit_done) begin
          m_res = muxout; m_done = 1; m_busy = 0;
        end else if (m_age - 1 == TO) begin
          m_err = 1; m_done = 1; m_busy = 0;
        end
      end
    end
  end

  task automatic mcheck();
    logic [15:0] eh;
    eh = m_busy ? (16'h0001 << m_op) : 16'h0000;
    chk("hotselect", hotselect, eh);
    chk("onehot", $onehot0(hotselect), 1);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("unit_start", unit_start, m_us);
    chk("result", result, m_res);
    chk("last_op", last_op, m_last);
    chk("err", err, m_err);
  endtask

  task automatic tick();
    @(negedge clk);
    mcheck();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    mcheck();
    chk("rst_hot", hotselect, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    rst = 1'b0;

    // combinational op 3
    muxout = 32'h0000_0042; start = 1; opcode = 4'd3;
    tick();
    chk("c_hot", hotselect, 16'h0008);
    chk("c_busy", busy, 1);
    start = 0;
    tick();
    chk("c_done", done, 1);
    chk("c_result", result, 32'h42);
    chk("c_busy0", busy, 0);
    chk("c_last", last_op, 3);
    tick();
    chk("c_done1", done, 0);

    // multi-cycle op 10, unit_done seen 3 edges after unit_start rises
    muxout = 32'hDEAD_BEEF; start = 1; opcode = 4'd10;
    tick();
    chk("m_hot", hotselect, 16'h0400);
    start = 0;
    tick();
    chk("m_us", unit_start, 1);
    tick();
    chk("m_us0", unit_start, 0);
    tick();
    unit_done = 1;
    tick();
    unit_done = 0;
    chk("m_done", done, 1);
    chk("m_result", result, 32'hDEADBEEF);
    chk("m_err", err, 0);
    tick();

    // timeout on op 11
    muxout = 32'h1234_5678; start = 1; opcode = 4'd11;
    tick();
    start = 0;
    tick();
    chk("t_us", unit_start, 1);
    repeat (TO - 1) tick();
    chk("t_early", done, 0);
    tick();
    chk("t_done", done, 1);
    chk("t_err", err, 1);
    chk("t_result", result, 32'hDEADBEEF);
    start = 1; opcode = 4'd0;
    tick();
    chk("t_errclr", err, 0);
    chk("b_hot0", hotselect, 16'h0001);
    start = 0;
    tick();

    // start held while busy
    start = 1; opcode = 4'd5;
    tick();
    opcode = 4'd7;
    tick();
    chk("h_last", last_op, 5);
    start = 0;
    tick();

    // clear wins over start
    clear = 1; start = 1; opcode = 4'd9;
    tick();
    clear = 0; start = 0;
    chk("cl_result", result, 0);
    chk("cl_busy", busy, 0);
    chk("cl_last", last_op, 0);
    tick();

    // boundary opcode 15
    start = 1; opcode = 4'd15;
    tick();
    chk("b_hot15", hotselect, 16'h8000);
    start = 0;
    tick();
    tick();

    // reset during WAIT
    start = 1; opcode = 4'd10;
    tick();
    start = 0;
    tick();
    tick();
    #2 rst = 1;
    #1;
    mcheck();
    chk("r_hot", hotselect, 0);
    chk("r_busy", busy, 0);
    chk("r_us", unit_start, 0);
    #1 rst = 0;
    tick();
    chk("r_nodone", done, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      start     = ($urandom % 3) == 0;
      opcode    = ($urandom % 3 == 0) ? 4'(10 + $urandom % 2) : 4'($urandom);
      clear     = ($urandom % 8) == 0;
      muxout    = $urandom;
      unit_done = ($urandom % 5) == 0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Control block that sequences one calculator operation at a time through the 16-input one-hot result multiplexer. It accepts an opcode under a start handshake and drives the one-hot select. For multi-cycle units (multiply/divide) it issues a start pulse and waits for completion, with a timeout. It then captures the mux output into a result register and pulses done. It sits between the Python-facing command interface and the datapath.

## Interface
Parameters:
- WIDTH, 32, datapath/result width; must match mux width
- MC_MASK, 16'h0C00, bit i set means opcode i is multi-cycle and needs a unit_start/unit_done exchange
- TIMEOUT, 8, maximum WAIT cycles before abort; legal range 2..255

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a new operation; sampled only in IDLE
- opcode  in  4  operation index 0..15, sampled with start
- clear  in  1  clears result, last_op and err; honoured only in IDLE
- muxout  in  WIDTH  multiplexer output, combinational from hotselect
- unit_done  in  1  completion from the selected multi-cycle unit
- hotselect  out  16  registered one-hot select to the multiplexer; all-zero when idle
- unit_start  out  1  one-cycle pulse to the multi-cycle unit
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle completion pulse; also pulses on timeout
- result  out  WIDTH  last captured muxout
- last_op  out  4  opcode of the last accepted operation
- err  out  1  sticky timeout flag

## Operation
- States: IDLE, SELECT, WAIT.
- IDLE:
  - clear=1: result<=0, last_op<=0, err<=0. A start in the same cycle is ignored (clear wins).
  - Otherwise start=1: op_q<=opcode, last_op<=opcode, err<=0, hotselect<=1<<opcode, go to SELECT.
- SELECT:
  - If MC_MASK[op_q]=0: result<=muxout, done<=1, hotselect<=0, go to IDLE.
  - Else: unit_start<=1, cnt<=0, go to WAIT. hotselect is held.
- WAIT:
  - unit_start returns to 0 after its single cycle.
  - unit_done=1: result<=muxout, done<=1, hotselect<=0, go to IDLE.
  - Else if cnt==TIMEOUT-1: err<=1, done<=1, result unchanged, hotselect<=0, go to IDLE.
  - Else cnt<=cnt+1.
  - unit_done and timeout in the same cycle: unit_done wins, err stays 0.
- start while busy is ignored. There is no queue and no error.
- clear while busy is ignored.
- unit_done outside WAIT is ignored.
- hotselect is never multi-hot. It is all-zero in IDLE and after reset.
- cnt is 8 bits wide and never wraps, since TIMEOUT is at most 255.

## Timing
- Reset (asynchronous, immediate): state=IDLE, hotselect=0, unit_start=0, busy=0, done=0, result=0, last_op=0, err=0, cnt=0. Reset mid-operation aborts with no done pulse.
- Combinational op: start sampled at edge k; hotselect valid after k; result and done valid after k+1; busy high for the cycle between k and k+1.
- Multi-cycle op: unit_start high for the cycle after k+1. If unit_done is first seen at edge k+1+n (n≥1), result and done appear after that edge.
- Timeout: with no unit_done, done=1 and err=1 appear after edge k+1+TIMEOUT.
- done is high for exactly one cycle. A new start may be sampled in the same cycle done is high, since state is already IDLE.
- Back-to-back combinational ops therefore sustain one operation per 2 cycles.

## Test plan
- Reset mid-flight: rst during WAIT → all outputs 0 immediately; no done; next start behaves normally.
- Combinational op: muxout=32'h0000_0042, start with opcode=3 → hotselect=16'h0008 for 1 cycle; then result=32'h42, done=1 for 1 cycle, busy back to 0, last_op=3.
- Multi-cycle op: opcode=10, unit_done asserted 3 cycles after unit_start, muxout=32'hDEAD_BEEF → hotselect=16'h0400 throughout; single unit_start pulse; result=32'hDEADBEEF; err=0.
- Timeout: opcode=11 with unit_done never asserted, TIMEOUT=8 → done and err rise 8 cycles after unit_start; result retains its prior value; the next start clears err.
- Collisions:
  - start held high during a busy op → second request ignored; last_op unchanged.
  - clear and start in the same IDLE cycle → result=0, no op launched.
- Boundary opcodes 0 and 15 → hotselect 16'h0001 and 16'h8000 respectively; at no time more than one bit set (assertion).
